// File: rtl/div_ratio_sched_pkg.sv
// Shared types and helpers for the div_ratio_sched clock-divider controller:
// FSM states, minimum legal ratio and the fout high/low threshold.
package div_ratio_sched_pkg;

    typedef enum logic {RUN, HOLD} state_e;

    localparam int MIN_DIV = 2;
    localparam int MAX_W   = 16;

    // Length of the low phase: ceil(ratio/2), so odd ratios get the extra low cycle.
    function automatic logic [MAX_W-1:0] half_of(input logic [MAX_W-1:0] ratio);
        logic [MAX_W:0] sum;
        sum = {1'b0, ratio} + {{MAX_W{1'b0}}, 1'b1};
        return sum[MAX_W:1];
    endfunction

endpackage

// File: rtl/div_ratio_sched_arb.sv
// Combinational round-robin arbiter: the first active request at or after the
// pointer wins. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   winner_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Sum is one bit wider than the pointer so the wrap compare cannot overflow.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                winner_o      = idx;
            end
        end
    end

endmodule

// File: rtl/div_ratio_sched.sv
// Divide counter with glitch-free ratio changes arbitrated among NREQ requesters.
// Optional macro DIV_RATIO_SCHED_LOCK_EN adds a cfg_lock input that blocks new grants.
module div_ratio_sched
    import div_ratio_sched_pkg::*;
#(
    parameter int W         = 4,
    parameter int N_DEFAULT = 8,
    parameter int NREQ      = 2
) (
    input  logic              fin,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_div,
`ifdef DIV_RATIO_SCHED_LOCK_EN
    input  logic              cfg_lock,
`endif
    output logic [NREQ-1:0]   req_ack,
    output logic              cfg_err,
    output logic              pending,
    output logic [W-1:0]      cur_div,
    output logic [W-1:0]      cnt,
    output logic              tick,
    output logic              fout
);

    localparam int IW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  cur_div_q, cur_div_d;
    logic [W-1:0]  pend_div_q, pend_div_d;
    logic [IW-1:0] rr_q, rr_d;
    logic          cfg_err_q, cfg_err_d;
    logic          tick_q, tick_d;
    logic          fout_q, fout_d;

    logic [NREQ-1:0]  arbGrant;
    logic [IW-1:0]    arbWinner;
    logic [W-1:0]     winDiv;
    logic             grantEn;
    logic             isWrap;
    logic [MAX_W-1:0] halfD;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) arbiter (
        .req_i    (req_valid),
        .ptr_i    (rr_q),
        .grant_o  (arbGrant),
        .winner_o (arbWinner)
    );

    always_comb begin
        isWrap = (cnt_q == cur_div_q - W'(1));
`ifdef DIV_RATIO_SCHED_LOCK_EN
        grantEn = (state_q == RUN) && !cfg_lock && (|req_valid);
`else
        grantEn = (state_q == RUN) && (|req_valid);
`endif
        winDiv = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arbWinner == IW'(i)) begin
                winDiv = req_div[i*W +: W];
            end
        end
    end

    // A new ratio is only latched here; it reaches cur_div on a later wrap edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = isWrap ? '0 : cnt_q + W'(1);
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        rr_d       = rr_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (grantEn) begin
                    rr_d = (arbWinner == IW'(NREQ-1)) ? '0 : arbWinner + IW'(1);
                    if (winDiv >= W'(MIN_DIV)) begin
                        pend_div_d = winDiv;
                        state_d    = HOLD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (isWrap) begin
                    cur_div_d = pend_div_q;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        halfD  = half_of(MAX_W'(cur_div_d));
        fout_d = (MAX_W'(cnt_d) >= halfD);
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge fin or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            cur_div_q  <= W'(N_DEFAULT);
            pend_div_q <= '0;
            rr_q       <= '0;
            cfg_err_q  <= 1'b0;
            tick_q     <= 1'b0;
            fout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            rr_q       <= rr_d;
            cfg_err_q  <= cfg_err_d;
            tick_q     <= tick_d;
            fout_q     <= fout_d;
        end
    end

    assign req_ack = grantEn ? arbGrant : '0;
    assign cfg_err = cfg_err_q;
    assign pending = (state_q == HOLD);
    assign cur_div = cur_div_q;
    assign cnt     = cnt_q;
    assign tick    = tick_q;
    assign fout    = fout_q;

endmodule
